// File: rtl/benes_pkg.sv
// Shared types and sizing for the Benes scheduler control block.
package benes_pkg;

    localparam int N_PORTS  = 8;
    localparam int N_STAGES = 5;
    localparam int SW_W     = 4;
    localparam int CFG_W    = 20;
    localparam int N_SLOTS  = 4;
    localparam int NET_LAT  = 9;
    localparam int SLOT_W   = $clog2(N_SLOTS);

    typedef logic [CFG_W-1:0] cfg_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic logic [SW_W-1:0] stage_bits(input cfg_t cfg, input int stage);
        return cfg[stage*SW_W +: SW_W];
    endfunction

endpackage

// File: rtl/benes_cfg_skew.sv
// Per-stage skew line: carries each accepted frame's config so stage k sees it before edge T+2k.
// Latency: stage k register loads at edge T+2k-1, out_valid rises after edge T+8.
// Backpressure: none, accepts one frame per cycle unconditionally.
module benes_cfg_skew
    import benes_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               acc,
    input  cfg_t                               acc_cfg,
    output logic [N_STAGES-1:1][SW_W-1:0]      stage_set,
    output logic                               out_valid,
    output logic                               in_flight
);

    localparam int VLD_DEPTH = NET_LAT - 1;
    // The last stage loads from index 2*(N_STAGES-1)-2, so config need not travel further.
    localparam int CFG_DEPTH = 2 * N_STAGES - 3;

    logic [VLD_DEPTH-1:0]            vld_q;
    cfg_t                            cfg_q [CFG_DEPTH];
    logic [N_STAGES-1:1][SW_W-1:0]   stage_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q     <= '0;
            stage_q   <= '0;
            out_valid <= 1'b0;
            for (int i = 0; i < CFG_DEPTH; i++) begin
                cfg_q[i] <= '0;
            end
        end else begin
            vld_q     <= {vld_q[VLD_DEPTH-2:0], acc};
            out_valid <= vld_q[VLD_DEPTH-1];
            cfg_q[0]  <= acc_cfg;
            for (int i = 1; i < CFG_DEPTH; i++) begin
                cfg_q[i] <= cfg_q[i-1];
            end
            for (int k = 1; k < N_STAGES; k++) begin
                if (vld_q[2*k-2]) begin
                    stage_q[k] <= stage_bits(cfg_q[2*k-2], k);
                end
            end
        end
    end

    assign stage_set = stage_q;
    assign in_flight = (|vld_q) | out_valid;

endmodule

// File: rtl/benes_sched_ctrl.sv
// Slot-table scheduler for an 8x8 Benes network; BENES_FRAME_CNT_EN builds the frame counter.
// Latency: stage 0 combinational at acceptance, stage k before edge T+2k, out_valid after T+8.
// Backpressure: in_ready only in RUN with stop low; no downstream backpressure.
module benes_sched_ctrl
    import benes_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_wr_en,
    input  logic [SLOT_W-1:0]              cfg_wr_slot,
    input  logic [CFG_W-1:0]               cfg_wr_data,
    input  logic                           start,
    input  logic                           stop,
    input  logic                           in_valid,
    input  logic [SLOT_W-1:0]              in_slot,
    output logic                           in_ready,
    output logic [N_STAGES-1:0][SW_W-1:0]  switch_set,
    output logic                           out_valid,
    output logic                           busy,
    output logic                           done,
    output logic [15:0]                    frame_cnt
);

    state_e                         state_q;
    state_e                         state_d;
    cfg_t                           tbl_q [N_SLOTS];
    cfg_t                           sel_cfg;
    logic                           acc;
    logic                           in_flight;
    logic [SW_W-1:0]                sw0_q;
    logic [SW_W-1:0]                sw0;
    logic [N_STAGES-1:1][SW_W-1:0]  stage_set;

    assign in_ready = (state_q == ST_RUN) && !stop;
    assign acc      = in_valid && in_ready;
    // Read before the same-edge write lands, so a colliding write never reaches this frame.
    assign sel_cfg  = tbl_q[in_slot];
    assign sw0      = acc ? stage_bits(sel_cfg, 0) : sw0_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                tbl_q[i] <= '0;
            end
        end else if (cfg_wr_en) begin
            tbl_q[cfg_wr_slot] <= cfg_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sw0_q   <= '0;
        end else begin
            state_q <= state_d;
            if (acc) begin
                sw0_q <= stage_bits(sel_cfg, 0);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start && !stop) state_d = ST_RUN;
            ST_RUN:   if (stop)           state_d = ST_DRAIN;
            ST_DRAIN: if (!in_flight)     state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
    end

    benes_cfg_skew u_skew (
        .clk       (clk),
        .rst       (rst),
        .acc       (acc),
        .acc_cfg   (sel_cfg),
        .stage_set (stage_set),
        .out_valid (out_valid),
        .in_flight (in_flight)
    );

    assign switch_set = {stage_set, sw0};
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DRAIN) && !in_flight;

`ifdef BENES_FRAME_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_q == ST_IDLE && state_d == ST_RUN) begin
            cnt_q <= '0;
        end else if (acc && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign frame_cnt = cnt_q;
`else
    assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_benes_sched_ctrl.sv
// Directed bench for benes_sched_ctrl; expected values are hand-derived from frame acceptance times.
module tb_benes_sched_ctrl;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_wr_en;
    logic [1:0]        cfg_wr_slot;
    logic [19:0]       cfg_wr_data;
    logic              start;
    logic              stop;
    logic              in_valid;
    logic [1:0]        in_slot;
    logic              in_ready;
    logic [4:0][3:0]   switch_set;
    logic              out_valid;
    logic              busy;
    logic              done;
    logic [15:0]       frame_cnt;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef BENES_FRAME_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic [19:0] exp_cfg [16];
    logic [1:0]  slot_q  [16];
    int          wr_at;
    logic [1:0]  wr_slot;
    logic [19:0] wr_data;

    always #5 clk = ~clk;

    benes_sched_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_wr_en   (cfg_wr_en),
        .cfg_wr_slot (cfg_wr_slot),
        .cfg_wr_data (cfg_wr_data),
        .start       (start),
        .stop        (stop),
        .in_valid    (in_valid),
        .in_slot     (in_slot),
        .in_ready    (in_ready),
        .switch_set  (switch_set),
        .out_valid   (out_valid),
        .busy        (busy),
        .done        (done),
        .frame_cnt   (frame_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_tbl(input logic [1:0] slot, input logic [19:0] data);
        cfg_wr_en = 1'b1; cfg_wr_slot = slot; cfg_wr_data = data;
        tick();
        cfg_wr_en = 1'b0;
    endtask

    task automatic restart();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        for (int c = 0; c < 40 && busy; c++) tick();
        chk("idle_before_start", {31'd0, busy}, 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    // Frame j is accepted at edge T0+j; after edge T0+j stage k shows frame j-(2k-1).
    task automatic run_burst(input int n);
        for (int j = 0; j < n + 10; j++) begin
            in_valid  = (j < n);
            in_slot   = (j < n) ? slot_q[j] : 2'd0;
            cfg_wr_en = (j == wr_at);
            cfg_wr_slot = wr_slot;
            cfg_wr_data = wr_data;
            #1;
            if (j < n) begin
                chk($sformatf("rdy[%0d]", j), {31'd0, in_ready}, 32'd1);
                chk($sformatf("ss0[%0d]", j), {28'd0, switch_set[0]}, {28'd0, exp_cfg[j][3:0]});
            end else begin
                chk($sformatf("ss0_hold[%0d]", j), {28'd0, switch_set[0]}, {28'd0, exp_cfg[n-1][3:0]});
            end
            @(posedge clk);
            #1;
            for (int k = 1; k < 5; k++) begin
                int i;
                i = j - (2 * k - 1);
                if (i >= n) i = n - 1;
                if (i >= 0)
                    chk($sformatf("ss%0d[e%0d]", k, j), {28'd0, switch_set[k]},
                        {28'd0, exp_cfg[i][k*4 +: 4]});
            end
            chk($sformatf("ovld[e%0d]", j), {31'd0, out_valid},
                {31'd0, (j >= 8 && j - 8 < n)});
        end
        in_valid = 1'b0; cfg_wr_en = 1'b0; wr_at = -1;
    endtask

    initial begin
        rst = 1'b1; cfg_wr_en = 1'b0; cfg_wr_slot = '0; cfg_wr_data = '0;
        start = 1'b0; stop = 1'b0; in_valid = 1'b0; in_slot = '0; wr_at = -1;
        wr_slot = '0; wr_data = '0;
        #3;
        chk("rst_switch_set", {12'd0, switch_set}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // start together with stop stays in IDLE
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("start_stop_idle", {31'd0, busy}, 32'd0);

        // single frame, distinct nibbles per stage
        wr_tbl(2'd1, 20'h12345);
        start = 1'b1; tick(); start = 1'b0;
        slot_q[0] = 2'd1; exp_cfg[0] = 20'h12345;
        run_burst(1);

        // eight back-to-back alternating frames
        wr_tbl(2'd0, 20'h00000);
        wr_tbl(2'd2, 20'hFFFFF);
        restart();
        for (int i = 0; i < 8; i++) begin
            slot_q[i]  = (i % 2) ? 2'd2 : 2'd0;
            exp_cfg[i] = (i % 2) ? 20'hFFFFF : 20'h00000;
        end
        run_burst(8);
        chk("frame_cnt_8", {16'd0, frame_cnt}, CNT_EN ? 32'd8 : 32'd0);

        // write to the issuing slot at the acceptance edge
        wr_tbl(2'd1, 20'h55555);
        slot_q[0] = 2'd1; exp_cfg[0] = 20'h55555;
        slot_q[1] = 2'd1; exp_cfg[1] = 20'hAAAAA;
        wr_at = 0; wr_slot = 2'd1; wr_data = 20'hAAAAA;
        run_burst(2);

        // stop one cycle after the last acceptance, then drain
        restart();
        in_valid = 1'b1; in_slot = 2'd0;
        tick();
        stop = 1'b1;
        #1;
        chk("stop_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        stop = 1'b0; in_valid = 1'b0;
        begin
            int n_done;
            n_done = 0;
            for (int j = 1; j <= 12; j++) begin
                chk($sformatf("drain_ovld[e%0d]", j), {31'd0, out_valid}, {31'd0, (j == 8)});
                chk($sformatf("drain_done[e%0d]", j), {31'd0, done}, {31'd0, (j == 9)});
                chk($sformatf("drain_busy[e%0d]", j), {31'd0, busy}, {31'd0, (j <= 9)});
                if (done) n_done++;
                tick();
            end
            chk("done_pulses", n_done, 32'd1);
        end

        // reset three cycles after an acceptance
        start = 1'b1; tick(); start = 1'b0;
        in_valid = 1'b1; in_slot = 2'd1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_switch_set", {12'd0, switch_set}, 32'd0);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("mid_rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        begin
            int n_ov;
            n_ov = 0;
            for (int j = 0; j < 12; j++) begin
                if (out_valid) n_ov++;
                tick();
            end
            chk("post_rst_no_ovld", n_ov, 32'd0);
            chk("post_rst_idle", {31'd0, busy}, 32'd0);
        end
        start = 1'b1; tick(); start = 1'b0;
        in_valid = 1'b1; in_slot = 2'd1;
        #1;
        chk("post_rst_tbl_clear", {28'd0, switch_set[0]}, 32'd0);
        tick();
        in_valid = 1'b0;

        // counter saturation (or stays zero without the counter)
        restart();
        in_valid = 1'b1; in_slot = 2'd0;
`ifdef BENES_FRAME_CNT_EN
        for (int i = 0; i < 65540; i++) tick();
        chk("frame_cnt_sat", {16'd0, frame_cnt}, 32'h0000FFFF);
`else
        for (int i = 0; i < 20; i++) tick();
        chk("frame_cnt_zero", {16'd0, frame_cnt}, 32'd0);
`endif
        in_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
